abs_sign_decoder: RTL and testbench

//  Iterative sign-magnitude decoder: splits an XLEN-bit two's-complement operand into sign
//  and magnitude |A|, the inverse of the negation path. Processes CHUNK bits/cycle with a

---
 rtl/abs_sign_decoder.sv | 120 ++++++++++++
 tb/tb_abs_sign_decoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/abs_sign_decoder.sv
// abs_sign_decoder
//   Iterative sign-magnitude decoder. Splits an XLEN-bit two's-complement
//   operand into its sign and unsigned magnitude |A|, CHUNK bits per cycle,
//   rippling the +1 of the negation through a one-bit carry register.
//   Optional build macro: ABS_BYPASS_EN (non-negative operands skip RUN).
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high; the producer keeps its data stable while valid is high and
//   ready is low, and out_valid stays high (with mag/sign/ovf frozen) until
//   out_ready is seen.
module abs_sign_decoder #(
   parameter int XLEN  = 64,
   parameter int CHUNK = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] A,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] mag,
   output logic            sign,
   output logic            ovf,
   output logic [1:0]      dbg_state
);

   localparam int NCHUNK = XLEN / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] a_q;
   logic [XLEN-1:0] mag_q;
   logic            sign_q;
   logic            carry_q;
   logic [IDXW-1:0] idx_q;

   logic            accept;
   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK:0]   sum;
   logic [CHUNK-1:0] new_chunk;

   assign accept    = (state_q == S_IDLE) && in_valid;
   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign mag       = mag_q;
   assign sign      = sign_q;
   assign ovf       = (state_q == S_DONE) && sign_q && (mag_q == MOST_NEG);
   assign dbg_state = state_q;

   // Select the current chunk of the latched operand and form its negated value.
   always_comb begin
      a_chunk = '0;
      for (int k = 0; k < NCHUNK; k++) begin
         if (idx_q == IDXW'(k)) a_chunk = a_q[k*CHUNK +: CHUNK];
      end
      sum       = {1'b0, ~a_chunk} + {{CHUNK{1'b0}}, carry_q};
      new_chunk = sign_q ? sum[CHUNK-1:0] : a_chunk;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: IDLE -> RUN for XLEN/CHUNK cycles -> DONE until taken.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
`ifdef ABS_BYPASS_EN
               state_d = A[XLEN-1] ? S_RUN : S_DONE;
`else
               state_d = S_RUN;
`endif
            end
         end
         S_RUN:   if (idx_q == LAST_IDX) state_d = S_DONE;
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: latch the operand on accept, then rebuild mag one chunk per RUN cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         mag_q   <= '0;
         sign_q  <= 1'b0;
         carry_q <= 1'b1;
         idx_q   <= '0;
      end else if (accept) begin
         a_q     <= A;
         sign_q  <= A[XLEN-1];
         carry_q <= 1'b1;
         idx_q   <= '0;
`ifdef ABS_BYPASS_EN
         if (!A[XLEN-1]) mag_q <= A;
`endif
      end else if (state_q == S_RUN) begin
         for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IDXW'(k)) mag_q[k*CHUNK +: CHUNK] <= new_chunk;
         end
         // Carry out of the last chunk is simply dropped on the next accept.
         if (sign_q) carry_q <= sum[CHUNK];
         idx_q <= idx_q + IDXW'(1);
      end
   end

endmodule

// File: tb/tb_abs_sign_decoder.sv
// tb_abs_sign_decoder
//   Directed plus a few random operands through abs_sign_decoder. Expected
//   {sign, ovf, mag} tuples are queued when an operand is driven and popped
//   when the result handshake occurs.
module tb_abs_sign_decoder;

   localparam int XLEN    = 64;
   localparam int RUN_LAT = 9;
   localparam int TMO     = 40;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] A;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] mag;
   logic            sign;
   logic            ovf;
   logic [1:0]      dbg_state;

   int n_cmp = 0;
   int n_err = 0;
   logic [XLEN+1:0] exp_q[$];

   // Clock.
   always #5 clk = ~clk;

   // Global time limit.
   initial begin
      #400000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   abs_sign_decoder #(.XLEN(64), .CHUNK(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .mag       (mag),
      .sign      (sign),
      .ovf       (ovf),
      .dbg_state (dbg_state)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference: sign bit, overflow flag for the most-negative value, and |A|.
   function automatic logic [XLEN+1:0] model(input logic [XLEN-1:0] a);
      logic            s;
      logic            o;
      logic [XLEN-1:0] m;
      s = a[XLEN-1];
      m = s ? (64'd0 - a) : a;
      o = s && (m == 64'h8000_0000_0000_0000);
      return {s, o, m};
   endfunction

   function automatic int exp_lat(input logic [XLEN-1:0] a);
`ifdef ABS_BYPASS_EN
      if (!a[XLEN-1]) return 1;
`endif
      return RUN_LAT;
   endfunction

   // Drive one operand and return just after the accepting edge.
   task automatic send(input logic [XLEN-1:0] a);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < TMO) begin
         @(negedge clk);
         guard++;
      end
      check("send_in_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      A        = a;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      A        = {$urandom, $urandom};
   endtask

   // Wait for out_valid, check latency and the popped expectation.
   task automatic wait_result(input string tag, input int lat);
      int k;
      logic [XLEN+1:0] e;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!out_valid && k < TMO);
      check({tag, "_latency"}, 64'(k), 64'(lat));
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
         e = '0;
      end else begin
         e = exp_q.pop_front();
      end
      check({tag, "_sign"}, 64'(sign), 64'(e[XLEN+1]));
      check({tag, "_ovf"}, 64'(ovf), 64'(e[XLEN]));
      check({tag, "_mag"}, mag, e[XLEN-1:0]);
      check({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
      if (out_ready) begin
         @(negedge clk);
         check({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
         check({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
      end
   endtask

   logic [XLEN-1:0] a_r;
   int              stray;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      A         = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state.
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_mag", mag, 64'd0);
      check("rst_sign", 64'(sign), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);

      // Small positive and its negation.
      exp_q.push_back({1'b0, 1'b0, 64'd3});
      send(64'd3);
      wait_result("pos3", exp_lat(64'd3));
      exp_q.push_back({1'b1, 1'b0, 64'd3});
      send(64'hFFFF_FFFF_FFFF_FFFD);
      wait_result("neg3", RUN_LAT);

      // Back-to-back sequence: zero, -33, -1.
      exp_q.push_back({1'b0, 1'b0, 64'd0});
      exp_q.push_back({1'b1, 1'b0, 64'd33});
      exp_q.push_back({1'b1, 1'b0, 64'd1});
      send(64'd0);
      wait_result("zero", exp_lat(64'd0));
      send(64'hFFFF_FFFF_FFFF_FFDF);
      wait_result("neg33", RUN_LAT);
      send(64'hFFFF_FFFF_FFFF_FFFF);
      wait_result("neg1", RUN_LAT);

      // Most-negative value.
      exp_q.push_back({1'b1, 1'b1, 64'h8000_0000_0000_0000});
      send(64'h8000_0000_0000_0000);
      wait_result("most_neg", RUN_LAT);

      // Largest positive value.
      exp_q.push_back({1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF});
      send(64'h7FFF_FFFF_FFFF_FFFF);
      wait_result("max_pos", exp_lat(64'h7FFF_FFFF_FFFF_FFFF));

      // Backpressure in DONE with a stray in_valid pulse.
      out_ready = 1'b0;
      exp_q.push_back({1'b1, 1'b0, 64'd33});
      send(64'hFFFF_FFFF_FFFF_FFDF);
      wait_result("stall", RUN_LAT);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 1) begin
            in_valid = 1'b1;
            A        = 64'd7;
         end
         if (i == 2) in_valid = 1'b0;
         check("stall_out_valid", 64'(out_valid), 64'd1);
         check("stall_mag", mag, 64'd33);
         check("stall_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("stall_release_in_ready", 64'(in_ready), 64'd1);
      stray = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) stray++;
      end
      check("stall_no_stray_result", 64'(stray), 64'd0);

      // Reset in the middle of RUN (chunk index 4).
      send(64'hFFFF_FFFF_FFFF_FFFD);
      repeat (4) @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_mag", mag, 64'd0);
      check("midrst_sign", 64'(sign), 64'd0);
      rst = 1'b0;
      exp_q.push_back({1'b0, 1'b0, 64'd5});
      send(64'd5);
      wait_result("after_rst", exp_lat(64'd5));

      // A few random operands, alternating sign.
      for (int i = 0; i < 6; i++) begin
         a_r = {$urandom, $urandom};
         a_r[XLEN-1] = i[0];
         exp_q.push_back(model(a_r));
         send(a_r);
         wait_result("rand", exp_lat(a_r));
      end

      check("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
